// File: rtl/cdr_lock_controller_pkg.sv
// Shared types and default thresholds for the CDR lock sequencer.
// Imported by the sequencer top and by the error-window compare.
package cdr_lock_controller_pkg;

  localparam int GAIN_W = 4;
  localparam int ERR_W_DEF = 8;
  localparam int LOCK_THRESH_DEF = 2;
  localparam int UNLOCK_THRESH_DEF = 6;
  localparam int ACQ_QUAL_DEF = 16;
  localparam int LOCK_CYCLES_DEF = 64;
  localparam int UNLOCK_CYCLES_DEF = 16;
  localparam int ACQ_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_LOCKED  = 3'd4
  } cdr_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cdr_lock_controller_err_window.sv
// Phase error magnitude and window compares for the lock sequencer.
// Magnitude is one bit wider than the error so the most negative code fits.
module cdr_err_window
  import cdr_lock_controller_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF,
  parameter int LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int UNLOCK_THRESH = UNLOCK_THRESH_DEF
) (
  input  logic signed [ERR_W-1:0] phase_error,
  output logic        [ERR_W:0]   err_mag,
  output logic                    in_win,
  output logic                    abort
);

  logic signed [ERR_W:0] err_ext;

  assign err_ext = {phase_error[ERR_W-1], phase_error};

  always_comb begin
    err_mag = err_ext;
    if (err_ext < 0) err_mag = -err_ext;
  end

  assign in_win = err_mag <= (ERR_W+1)'(LOCK_THRESH);
  assign abort  = err_mag >  (ERR_W+1)'(UNLOCK_THRESH);

endmodule

// File: rtl/cdr_lock_controller.sv
// CDR acquisition/lock sequencer: picks loop-filter gains, clears the
// integrator on (re)acquisition and declares lock with hysteresis.
module cdr_lock_controller
  import cdr_lock_controller_pkg::*;
#(
  parameter int ERR_W = ERR_W_DEF,
  parameter int LOCK_THRESH = LOCK_THRESH_DEF,
  parameter int UNLOCK_THRESH = UNLOCK_THRESH_DEF,
  parameter int ACQ_QUAL = ACQ_QUAL_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int UNLOCK_CYCLES = UNLOCK_CYCLES_DEF,
  parameter int ACQ_TIMEOUT = ACQ_TIMEOUT_DEF,
  parameter logic [GAIN_W-1:0] KP_ACQ = 4'd2,
  parameter logic [GAIN_W-1:0] KI_ACQ = 4'd4,
  parameter logic [GAIN_W-1:0] KP_TRK = 4'd4,
  parameter logic [GAIN_W-1:0] KI_TRK = 4'd8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    err_valid,
  input  logic signed [ERR_W-1:0] phase_error,
  output logic [GAIN_W-1:0]       kp_shift,
  output logic [GAIN_W-1:0]       ki_shift,
  output logic                    lf_clear,
  output logic                    locked,
  output logic [2:0]              state_out,
  output logic                    acq_timeout,
  output logic [7:0]              relock_count
);

  localparam int IN_W  = $clog2(max2(ACQ_QUAL, LOCK_CYCLES) + 1);
  localparam int OUT_W = $clog2(UNLOCK_CYCLES + 1);
  localparam int TMO_W = $clog2(ACQ_TIMEOUT + 1);

  localparam logic [IN_W-1:0]  IN_QUAL = IN_W'(ACQ_QUAL - 1);
  localparam logic [IN_W-1:0]  IN_LOCK = IN_W'(LOCK_CYCLES - 1);
  localparam logic [OUT_W-1:0] OUT_END = OUT_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_END = TMO_W'(ACQ_TIMEOUT - 1);

  cdr_state_e state, state_d;
  logic [IN_W-1:0]  in_cnt, in_d;
  logic [OUT_W-1:0] out_cnt, out_d;
  logic [TMO_W-1:0] tmo_cnt, tmo_d;
  logic [7:0]       relock_d;
  logic             tmo_hit;
  logic [ERR_W:0]   err_mag;
  logic             in_win, abort;

  cdr_err_window #(
    .ERR_W(ERR_W),
    .LOCK_THRESH(LOCK_THRESH),
    .UNLOCK_THRESH(UNLOCK_THRESH)
  ) u_win (
    .phase_error(phase_error),
    .err_mag(err_mag),
    .in_win(in_win),
    .abort(abort)
  );

  always_comb begin
    state_d  = state;
    in_d     = in_cnt;
    out_d    = out_cnt;
    tmo_d    = tmo_cnt;
    relock_d = relock_count;
    tmo_hit  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      in_d    = '0;
      out_d   = '0;
      tmo_d   = '0;
    end else begin
      unique case (state)
        ST_IDLE: state_d = ST_CLEAR;
        ST_CLEAR: begin
          in_d    = '0;
          out_d   = '0;
          tmo_d   = '0;
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          if (tmo_cnt != TMO_END) tmo_d = tmo_cnt + 1'b1;
          if (err_valid) begin
            if (!in_win) in_d = '0;
            else if (!(&in_cnt)) in_d = in_cnt + 1'b1;
          end
          // qualification beats a coincident timeout
          if (err_valid && in_win && in_cnt >= IN_QUAL) begin
            state_d = ST_TRACK;
            in_d    = '0;
            tmo_d   = '0;
          end else if (tmo_cnt >= TMO_END) begin
            state_d = ST_CLEAR;
            tmo_hit = 1'b1;
          end
        end
        ST_TRACK: begin
          if (err_valid) begin
            if (abort) begin
              state_d = ST_ACQUIRE;
              in_d    = '0;
              tmo_d   = '0;
            end else if (!in_win) begin
              in_d = '0;
            end else if (in_cnt >= IN_LOCK) begin
              state_d = ST_LOCKED;
              in_d    = '0;
              out_d   = '0;
            end else begin
              in_d = in_cnt + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (err_valid) begin
            if (in_win) begin
              out_d = '0;
            end else if (out_cnt >= OUT_END) begin
              state_d = ST_ACQUIRE;
              out_d   = '0;
              in_d    = '0;
              tmo_d   = '0;
              if (!(&relock_count)) relock_d = relock_count + 1'b1;
            end else begin
              out_d = out_cnt + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      in_cnt       <= '0;
      out_cnt      <= '0;
      tmo_cnt      <= '0;
      relock_count <= '0;
      kp_shift     <= KP_ACQ;
      ki_shift     <= KI_ACQ;
      lf_clear     <= 1'b0;
      locked       <= 1'b0;
      acq_timeout  <= 1'b0;
    end else begin
      state        <= state_d;
      in_cnt       <= in_d;
      out_cnt      <= out_d;
      tmo_cnt      <= tmo_d;
      relock_count <= relock_d;
      lf_clear     <= state_d == ST_CLEAR;
      locked       <= state_d == ST_LOCKED;
      acq_timeout  <= tmo_hit;
      if (state_d == ST_TRACK || state_d == ST_LOCKED) begin
        kp_shift <= KP_TRK;
        ki_shift <= KI_TRK;
      end else begin
        kp_shift <= KP_ACQ;
        ki_shift <= KI_ACQ;
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_cdr_lock_controller.sv
// Directed-vector bench for the CDR lock sequencer.
// Expected values are hand-derived from the state timeline.
module tb_cdr_lock_controller;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              err_valid;
  logic signed [7:0] phase_error;
  logic [3:0]        kp_shift, ki_shift;
  logic              lf_clear, locked, acq_timeout;
  logic [2:0]        state_out;
  logic [7:0]        relock_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdr_lock_controller dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .err_valid(err_valid),
    .phase_error(phase_error),
    .kp_shift(kp_shift),
    .ki_shift(ki_shift),
    .lf_clear(lf_clear),
    .locked(locked),
    .state_out(state_out),
    .acq_timeout(acq_timeout),
    .relock_count(relock_count)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_st"}, state_out, 0);
    chk({tag, "_kp"}, kp_shift, 2);
    chk({tag, "_ki"}, ki_shift, 4);
    chk({tag, "_clr"}, lf_clear, 0);
    chk({tag, "_lck"}, locked, 0);
    chk({tag, "_tmo"}, acq_timeout, 0);
    chk({tag, "_rel"}, relock_count, 0);
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    err_valid = 1'b1;
    phase_error = 8'sd0;
    step(3);
    chk_reset_vals("rst");

    // acquisition to lock with zero error
    reset = 1'b1;
    enable = 1'b1;
    step(1);
    chk("t1_clear_st", state_out, 1);
    chk("t1_clear_pulse", lf_clear, 1);
    step(1);
    chk("t1_acq_st", state_out, 2);
    chk("t1_clear_done", lf_clear, 0);
    chk("t1_acq_kp", kp_shift, 2);
    chk("t1_acq_ki", ki_shift, 4);
    step(15);
    chk("t1_acq15", state_out, 2);
    step(1);
    chk("t1_trk_st", state_out, 3);
    chk("t1_trk_kp", kp_shift, 4);
    chk("t1_trk_ki", ki_shift, 8);
    step(63);
    chk("t1_trk63_st", state_out, 3);
    chk("t1_trk63_lck", locked, 0);
    step(1);
    chk("t1_lock_st", state_out, 4);
    chk("t1_lock", locked, 1);

    // lock-loss hysteresis
    phase_error = 8'sd3;
    step(15);
    chk("t4_bad15", locked, 1);
    phase_error = 8'sd0;
    step(1);
    chk("t4_good", locked, 1);
    phase_error = -8'sd128;
    step(15);
    chk("t4_m128_15", locked, 1);
    chk("t4_m128_15st", state_out, 4);
    step(1);
    chk("t4_drop", locked, 0);
    chk("t4_drop_st", state_out, 2);
    chk("t4_relock", relock_count, 1);
    chk("t4_noclr", lf_clear, 0);
    chk("t4_kp", kp_shift, 2);

    // a single out-of-window sample restarts qualification
    phase_error = 8'sd1;
    step(15);
    chk("t2_p1", state_out, 2);
    phase_error = -8'sd3;
    step(1);
    chk("t2_m3", state_out, 2);
    phase_error = 8'sd0;
    step(15);
    chk("t2_z15", state_out, 2);
    step(1);
    chk("t2_trk", state_out, 3);

    // abort from TRACK, no integrator clear
    phase_error = 8'sd7;
    step(1);
    chk("t5_abort_st", state_out, 2);
    chk("t5_abort_clr", lf_clear, 0);
    phase_error = 8'sd0;
    step(16);
    chk("t6_trk", state_out, 3);

    // invalid samples freeze the window counter
    step(30);
    err_valid = 1'b0;
    phase_error = 8'sd7;
    step(10);
    chk("t6_frozen_st", state_out, 3);
    err_valid = 1'b1;
    phase_error = 8'sd0;
    step(33);
    chk("t6_trk63", state_out, 3);
    step(1);
    chk("t6_lock", state_out, 4);

    // disable from LOCKED
    enable = 1'b0;
    step(1);
    chk("t5_dis_st", state_out, 0);
    chk("t5_dis_lck", locked, 0);
    chk("t5_dis_rel", relock_count, 1);
    chk("t5_dis_kp", kp_shift, 2);

    // window boundaries: |err|=2 in window, |err|=6 no abort
    enable = 1'b1;
    step(2);
    chk("b_acq", state_out, 2);
    phase_error = -8'sd2;
    step(16);
    chk("b_m2_trk", state_out, 3);
    phase_error = 8'sd6;
    step(1);
    chk("b_p6_stay", state_out, 3);
    phase_error = 8'sd0;
    step(63);
    chk("b_trk63", state_out, 3);
    step(1);
    chk("b_lock", locked, 1);

    // reset while LOCKED
    reset = 1'b0;
    step(1);
    chk_reset_vals("rst_lk");

    // acquisition timeout with constant +5 error
    reset = 1'b1;
    phase_error = 8'sd5;
    step(2);
    chk("t3_acq", state_out, 2);
    step(4095);
    chk("t3_pre_st", state_out, 2);
    chk("t3_pre_tmo", acq_timeout, 0);
    step(1);
    chk("t3_tmo", acq_timeout, 1);
    chk("t3_clr_st", state_out, 1);
    chk("t3_clr", lf_clear, 1);
    step(1);
    chk("t3_tmo_end", acq_timeout, 0);
    chk("t3_reacq", state_out, 2);
    step(4095);
    chk("t3_pre2", acq_timeout, 0);
    step(1);
    chk("t3_tmo2", acq_timeout, 1);
    chk("t3_clr2", lf_clear, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
